// File: rtl/ysyx_23060208_lsu.sv
// ysyx_23060208_lsu -- load/store unit between the EXU and the data-memory AXI4 port.
//
// Takes one load or store at a time from the EXU over a valid/ready handshake,
// runs a single-beat AXI4 transaction, and returns extended load data plus an
// error code through a response handshake that holds until accepted.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   req_*              EXU request (valid/ready, wen, addr, size, unsigned, wdata)
//   resp_*             EXU response (valid/ready, rdata, err: 0 ok, 1 bus, 2 misaligned)
//   dsram_aw/w/b/ar/r  AXI4 master channels (len=0, INCR, size=req_size)
//
// Optional feature: define YSYX_23060208_LSU_MISALIGN_CHECK_EN to reject
// requests whose address is not size-aligned (resp_err=2, no AXI traffic).
// Without it, misaligned accesses are issued as-is and lanes past the bus edge
// are dropped.
module ysyx_23060208_lsu #(
  parameter int XLEN   = 32,
  parameter int AXI_DW = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  dsram_awvalid,
  input  logic                  dsram_awready,
  output logic [ADDR_W-1:0]     dsram_awaddr,
  output logic [ID_W-1:0]       dsram_awid,
  output logic [7:0]            dsram_awlen,
  output logic [2:0]            dsram_awsize,
  output logic [1:0]            dsram_awburst,
  output logic                  dsram_wvalid,
  input  logic                  dsram_wready,
  output logic [AXI_DW-1:0]     dsram_wdata,
  output logic [AXI_DW/8-1:0]   dsram_wstrb,
  output logic                  dsram_wlast,
  input  logic                  dsram_bvalid,
  output logic                  dsram_bready,
  input  logic [1:0]            dsram_bresp,
  input  logic [ID_W-1:0]       dsram_bid,
  output logic                  dsram_arvalid,
  input  logic                  dsram_arready,
  output logic [ADDR_W-1:0]     dsram_araddr,
  output logic [ID_W-1:0]       dsram_arid,
  output logic [7:0]            dsram_arlen,
  output logic [2:0]            dsram_arsize,
  output logic [1:0]            dsram_arburst,
  input  logic                  dsram_rvalid,
  output logic                  dsram_rready,
  input  logic [AXI_DW-1:0]     dsram_rdata,
  input  logic [1:0]            dsram_rresp,
  input  logic                  dsram_rlast,
  input  logic [ID_W-1:0]       dsram_rid
);

  localparam int STRB_W = AXI_DW / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic              aw_done, w_done;
  logic [XLEN-1:0]   rdata_p1;
  logic [1:0]        err_p1;
  logic              accept;
  logic              misaligned;
  logic [OFF_W-1:0]  off_p0;

  // Byte strobes: (2^size) ones shifted up to the lane offset; anything that
  // falls off the top of the bus is dropped by the final truncation.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off,
                                                  input logic [1:0] size);
    logic [2*STRB_W-1:0] m;
    m = ({{(2*STRB_W-1){1'b0}}, 1'b1} << (4'd1 << size)) - 1'b1;
    m = m << off;
    return m[STRB_W-1:0];
  endfunction

  // Repeat the sized store operand across every lane so whichever lanes the
  // address selects already carry the right bytes.
  function automatic logic [AXI_DW-1:0] lane_wdata(input logic [XLEN-1:0] d,
                                                   input logic [1:0] size);
    logic [AXI_DW-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < STRB_W; j++) begin
      idx = j & ((1 << size) - 1) & (XLEN / 8 - 1);
      r[j*8 +: 8] = d[idx*8 +: 8];
    end
    return r;
  endfunction

  // Shift the addressed lane down, truncate to the access size, then sign- or
  // zero-extend. A size wider than XLEN degenerates to the full register.
  function automatic logic [XLEN-1:0] load_ext(input logic [AXI_DW-1:0] bus,
                                               input logic [OFF_W-1:0] off,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [AXI_DW-1:0] sh;
    logic [XLEN-1:0]   raw, mask;
    logic [XLEN:0]     m;
    int bits, top;
    sh   = bus >> {off, 3'b000};
    raw  = sh[XLEN-1:0];
    bits = 8 << size;
    m    = ({{XLEN{1'b0}}, 1'b1} << bits) - 1'b1;
    mask = m[XLEN-1:0];
    top  = (bits > XLEN) ? XLEN - 1 : bits - 1;
    raw  = raw & mask;
    if (!uns && raw[top]) raw = raw | ~mask;
    return raw;
  endfunction

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
  assign misaligned = |(req_addr[2:0] & ((3'd1 << req_size) - 3'd1));
`else
  assign misaligned = 1'b0;
`endif

  assign accept = req_valid && req_ready;
  assign off_p0 = addr_p0[OFF_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    dsram_arvalid = 1'b0;
    dsram_rready  = 1'b0;
    dsram_awvalid = 1'b0;
    dsram_wvalid  = 1'b0;
    dsram_bready  = 1'b0;
    resp_valid    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)   state_nxt = RESP;
          else if (req_wen) state_nxt = WR_AW;
          else              state_nxt = RD_A;
        end
      end
      RD_A: begin
        dsram_arvalid = 1'b1;
        if (dsram_arready) state_nxt = RD_D;
      end
      RD_D: begin
        dsram_rready = 1'b1;
        if (dsram_rvalid) state_nxt = RESP;
      end
      WR_AW: begin
        dsram_awvalid = !aw_done;
        dsram_wvalid  = !w_done;
        // Either channel may finish first; leave once both have handshaken.
        if ((aw_done || dsram_awready) && (w_done || dsram_wready)) state_nxt = WR_B;
      end
      WR_B: begin
        dsram_bready = 1'b1;
        if (dsram_bvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture stage
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= req_addr;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (dsram_awvalid && dsram_awready) aw_done <= 1'b1;
      if (dsram_wvalid && dsram_wready)   w_done  <= 1'b1;
    end
  end

  // Response capture stage
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_p1 <= '0;
      err_p1   <= 2'd0;
    end else if (accept && misaligned) begin
      rdata_p1 <= '0;
      err_p1   <= 2'd2;
    end else if (state == RD_D && dsram_rvalid) begin
      rdata_p1 <= load_ext(dsram_rdata, off_p0, size_p0, uns_p0);
      err_p1   <= (dsram_rresp != 2'b00) ? 2'd1 : 2'd0;
    end else if (state == WR_B && dsram_bvalid) begin
      rdata_p1 <= '0;
      err_p1   <= (dsram_bresp != 2'b00) ? 2'd1 : 2'd0;
    end
  end

  assign resp_rdata    = rdata_p1;
  assign resp_err      = err_p1;

  assign dsram_araddr  = addr_p0;
  assign dsram_arid    = ID_W'(AXI_ID);
  assign dsram_arlen   = 8'd0;
  assign dsram_arsize  = {1'b0, size_p0};
  assign dsram_arburst = 2'b01;

  assign dsram_awaddr  = addr_p0;
  assign dsram_awid    = ID_W'(AXI_ID);
  assign dsram_awlen   = 8'd0;
  assign dsram_awsize  = {1'b0, size_p0};
  assign dsram_awburst = 2'b01;

  assign dsram_wdata   = lane_wdata(wdata_p0, size_p0);
  assign dsram_wstrb   = lane_strb(off_p0, size_p0);
  assign dsram_wlast   = 1'b1;

  // Single outstanding single-beat transaction: IDs and rlast carry no information.
  logic unused_ok;
  assign unused_ok = ^{dsram_rid, dsram_bid, dsram_rlast};

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// tb_ysyx_23060208_lsu -- scoreboard bench for ysyx_23060208_lsu (XLEN=32, AXI_DW=64).
// Expected responses are queued when a request is issued and popped when the
// LSU presents resp_valid; the bench plays the AXI slave from the main thread.
module tb_ysyx_23060208_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  typedef struct packed {
    logic [31:0] rd;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  ysyx_23060208_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dsram_awvalid(awvalid), .dsram_awready(awready), .dsram_awaddr(awaddr),
    .dsram_awid(awid), .dsram_awlen(awlen), .dsram_awsize(awsize),
    .dsram_awburst(awburst),
    .dsram_wvalid(wvalid), .dsram_wready(wready), .dsram_wdata(wdata),
    .dsram_wstrb(wstrb), .dsram_wlast(wlast),
    .dsram_bvalid(bvalid), .dsram_bready(bready), .dsram_bresp(bresp),
    .dsram_bid(bid),
    .dsram_arvalid(arvalid), .dsram_arready(arready), .dsram_araddr(araddr),
    .dsram_arid(arid), .dsram_arlen(arlen), .dsram_arsize(arsize),
    .dsram_arburst(arburst),
    .dsram_rvalid(rvalid), .dsram_rready(rready), .dsram_rdata(rdata),
    .dsram_rresp(rresp), .dsram_rlast(rlast), .dsram_rid(rid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input int hold);
    exp_t e;
    for (int i = 0; i < 50 && !resp_valid; i++) tick();
    chk("resp_valid", resp_valid, 1);
    chk("sb_depth", sb.size(), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, e.rd);
      chk("hold_err", resp_err, e.err);
      chk("hold_req_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    chk("resp_rdata", resp_rdata, e.rd);
    chk("resp_err", resp_err, e.err);
    chk("req_ready_in_resp", req_ready, 0);
    tick();
    resp_ready = 1'b0;
    chk("req_ready_after", req_ready, 1);
    chk("resp_valid_after", resp_valid, 0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [63:0] bus, input logic [1:0] rr,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err, input int hold);
    issue(1'b0, addr, size, uns, 32'h0);
    sb.push_back('{rd: exp_rd, err: exp_err});
    for (int i = 0; i < 20 && !arvalid; i++) tick();
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, addr);
    chk("arsize", arsize, {1'b0, size});
    chk("arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 20 && !rready; i++) tick();
    chk("rready", rready, 1);
    rvalid = 1'b1; rdata = bus; rresp = rr;
    tick();
    rvalid = 1'b0;
    check_resp(hold);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                          input logic [1:0] br, input int aw_dly, input int w_dly,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wd, input int hold);
    int k, awc, wc;
    issue(1'b1, addr, size, 1'b0, wd);
    sb.push_back('{rd: 32'h0, err: (br != 2'b00) ? 2'd1 : 2'd0});
    k = 0; awc = 0; wc = 0;
    while ((awvalid || wvalid) && k < 30) begin
      if (k == 0) begin
        chk("awaddr", awaddr, addr);
        chk("awsize", awsize, {1'b0, size});
        chk("awlen_burst", {awlen, awburst}, {8'd0, 2'b01});
        chk("wstrb", wstrb, exp_strb);
        chk("wdata", wdata, exp_wd);
        chk("wlast", wlast, 1);
      end
      chk("bready_early", bready, 0);
      if (awvalid) awc++;
      if (wvalid) wc++;
      awready = (k >= aw_dly);
      wready  = (k >= w_dly);
      tick();
      k++;
    end
    awready = 1'b0; wready = 1'b0;
    chk("awvalid_cycles", awc, aw_dly + 1);
    chk("wvalid_cycles", wc, w_dly + 1);
    chk("bready", bready, 1);
    bvalid = 1'b1; bresp = br;
    tick();
    bvalid = 1'b0;
    chk("resp_after_b", resp_valid, 1);
    check_resp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
    resp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1; rid = 0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_axi_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    reset = 1'b0;
    tick();

    // Byte loads, signed and unsigned, from lane 5
    do_load(32'h8000_0005, 2'd0, 1'b0, 64'h0000_8000_0000_0000, 2'b00, 32'hFFFF_FF80, 2'd0, 0);
    do_load(32'h8000_0005, 2'd0, 1'b1, 64'h0000_8000_0000_0000, 2'b00, 32'h0000_0080, 2'd0, 0);
    // Half store to lanes 6-7
    do_store(32'h8000_0006, 2'd1, 32'hABCD_1234, 2'b00, 0, 0, 8'hC0, 64'h1234_1234_1234_1234, 0);
    // Word store with AW delayed three cycles
    do_store(32'h8000_0000, 2'd2, 32'hDEAD_BEEF, 2'b00, 3, 0, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF, 0);
    // Byte store, W delayed, bus error
    do_store(32'h8000_0003, 2'd0, 32'h0000_005A, 2'b10, 0, 2, 8'h08, 64'h5A5A_5A5A_5A5A_5A5A, 1);
    // Word load with SLVERR, response held off five cycles
    do_load(32'h8000_0004, 2'd2, 1'b0, 64'hCAFE_F00D_1234_5678, 2'b10, 32'hCAFE_F00D, 2'd1, 5);

    // Reset while waiting for read data abandons the load
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd_d_rready", rready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valids", {arvalid, rready, resp_valid}, 3'b0);
    chk("abort_req_ready", req_ready, 1);
    rvalid = 1'b1; rdata = 64'h1111_2222_3333_4444;
    tick();
    rvalid = 1'b0;
    chk("late_rvalid_resp", resp_valid, 0);
    chk("late_rvalid_req_ready", req_ready, 1);

    // Half loads from lanes 2-3 after the abort
    do_load(32'h8000_0002, 2'd1, 1'b1, 64'h0000_0000_8001_0000, 2'b00, 32'h0000_8001, 2'd0, 0);
    do_load(32'h8000_0002, 2'd1, 1'b0, 64'h0000_0000_8001_0000, 2'b00, 32'hFFFF_8001, 2'd0, 0);

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
    issue(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
    sb.push_back('{rd: 32'h0, err: 2'd2});
    chk("mis_no_arvalid", arvalid, 0);
    chk("mis_resp_next", resp_valid, 1);
    check_resp(0);
    issue(1'b1, 32'h8000_0001, 2'd1, 1'b0, 32'h1234);
    sb.push_back('{rd: 32'h0, err: 2'd2});
    chk("mis_no_awvalid", {awvalid, wvalid}, 2'b0);
    check_resp(0);
`else
    do_load(32'h8000_0002, 2'd2, 1'b0, 64'h1122_3344_5566_7788, 2'b00, 32'h3344_5566, 2'd0, 0);
    // Word store at lane 6 keeps only the two lanes that fit on the bus
    do_store(32'h8000_0006, 2'd2, 32'hA1B2_C3D4, 2'b00, 0, 0, 8'hC0, 64'hA1B2_C3D4_A1B2_C3D4, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
